// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between the two SPI master engines and the shared-bus arbiter.
interface spi_bus_arbiter_if;
   logic [1:0] req;
   logic [1:0] gnt;
   logic [1:0] m_sclk;
   logic [1:0] m_mosi;
   logic [1:0] m_cs_n;
   logic       SCLK;
   logic       MOSI;
   logic [1:0] CS_n;
   logic       timeout;
   logic       busy;

   // Requester side: the engines and the shared-bus observers.
   modport master (
      output req, m_sclk, m_mosi, m_cs_n,
      input  gnt, SCLK, MOSI, CS_n, timeout, busy
   );

   // Arbiter side.
   modport slave (
      input  req, m_sclk, m_mosi, m_cs_n,
      output gnt, SCLK, MOSI, CS_n, timeout, busy
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin req/gnt arbiter sharing one SPI bus between the ACL2 (0) and ALS (1)
// engines, with an idle guard gap between owners and a maximum hold timeout.
module spi_bus_arbiter #(
   parameter int unsigned GUARD_CYCLES = 8,
   parameter int unsigned MAX_HOLD     = 2000000,
   parameter int unsigned HOLD_W       = 21,
   parameter logic        CPOL         = 1'b0
) (
   input  logic               Clock,
   input  logic               Reset,
   spi_bus_arbiter_if.slave   bus
);

   localparam int unsigned GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic [1:0]          lockout_q, lockout_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [GUARD_W-1:0]  guard_q, guard_d;
   logic [1:0]          gnt_q, gnt_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic [1:0]          cs_n_q, cs_n_d;
   logic                timeout_q, timeout_d;
   logic [1:0]          elig;
   logic                win;

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         lockout_q <= 2'b00;
         hold_q    <= '0;
         guard_q   <= '0;
         gnt_q     <= 2'b00;
         sclk_q    <= CPOL;
         mosi_q    <= 1'b0;
         cs_n_q    <= 2'b11;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         lockout_q <= lockout_d;
         hold_q    <= hold_d;
         guard_q   <= guard_d;
         gnt_q     <= gnt_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         timeout_q <= timeout_d;
      end
   end

   // Arbitration, hold/guard timing and bus muxing; the bus idles on every edge
   // except those that keep the current owner in GRANT.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      lockout_d = lockout_q & bus.req;
      hold_d    = hold_q;
      guard_d   = guard_q;
      gnt_d     = gnt_q;
      sclk_d    = CPOL;
      mosi_d    = 1'b0;
      cs_n_d    = 2'b11;
      timeout_d = 1'b0;
      elig      = bus.req & ~lockout_q;
      win       = 1'b0;

      case (state_q)
         IDLE: begin
            if (elig != 2'b00) begin
               win          = (elig == 2'b11) ? ~last_q : elig[1];
               owner_d      = win;
               last_d       = win;
               gnt_d        = 2'b00;
               gnt_d[win]   = 1'b1;
               hold_d       = '0;
               state_d      = GRANT;
            end
         end
         GRANT: begin
            hold_d = hold_q + 1'b1;
            if (!bus.req[owner_q]) begin
               gnt_d   = 2'b00;
               guard_d = '0;
               state_d = GUARD;
            end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               gnt_d              = 2'b00;
               timeout_d          = 1'b1;
               lockout_d[owner_q] = 1'b1;
               guard_d            = '0;
               state_d            = GUARD;
            end else begin
               sclk_d          = bus.m_sclk[owner_q];
               mosi_d          = bus.m_mosi[owner_q];
               cs_n_d[owner_q] = bus.m_cs_n[owner_q];
            end
         end
         GUARD: begin
            if (guard_q == GUARD_W'(GUARD_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   assign bus.gnt     = gnt_q;
   assign bus.SCLK    = sclk_q;
   assign bus.MOSI    = mosi_q;
   assign bus.CS_n    = cs_n_q;
   assign bus.timeout = timeout_q;
   assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with GUARD_CYCLES=4, MAX_HOLD=16, CPOL=0.
module tb_spi_bus_arbiter;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 Clock = ~Clock;

   spi_bus_arbiter_if bus_if ();

   spi_bus_arbiter #(
      .GUARD_CYCLES (4),
      .MAX_HOLD     (16),
      .HOLD_W       (5),
      .CPOL         (1'b0)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus_if)
   );

   // Single comparison point: counts and reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] r, input logic [1:0] cs,
                        input logic [1:0] sclk, input logic [1:0] mosi);
      bus_if.req    = r;
      bus_if.m_cs_n = cs;
      bus_if.m_sclk = sclk;
      bus_if.m_mosi = mosi;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      drive(2'b00, 2'b11, 2'b00, 2'b00);
      tick();
      tick();
      Reset = 1'b1;
   endtask

   initial begin
      int n;
      int bad;
      int cyc;
      int ngr;
      int fall_cyc;
      int viol;
      int gap_viol;
      int age [2];
      logic [1:0] g;
      logic [1:0] prev;

      drive(2'b00, 2'b11, 2'b00, 2'b00);

      // 1: single requester, bus lags inputs by one cycle
      do_reset();
      check("rst_gnt", bus_if.gnt, 2'b00);
      check("rst_cs", bus_if.CS_n, 2'b11);
      check("rst_sclk", bus_if.SCLK, 1'b0);
      check("rst_mosi", bus_if.MOSI, 1'b0);
      check("rst_tmo", bus_if.timeout, 1'b0);
      check("rst_busy", bus_if.busy, 1'b0);
      drive(2'b01, 2'b11, 2'b00, 2'b00);
      tick();
      check("s1_gnt", bus_if.gnt, 2'b01);
      check("s1_cs_idle", bus_if.CS_n, 2'b11);
      check("s1_busy", bus_if.busy, 1'b1);
      drive(2'b01, 2'b00, 2'b11, 2'b11);
      tick();
      check("s1_cs_low", bus_if.CS_n, 2'b10);
      check("s1_sclk1", bus_if.SCLK, 1'b1);
      check("s1_mosi1", bus_if.MOSI, 1'b1);
      drive(2'b01, 2'b00, 2'b10, 2'b10);
      tick();
      check("s1_sclk0", bus_if.SCLK, 1'b0);
      check("s1_mosi0", bus_if.MOSI, 1'b0);
      check("s1_cs_hold", bus_if.CS_n, 2'b10);
      drive(2'b01, 2'b11, 2'b00, 2'b00);
      tick();
      check("s1_cs_rel", bus_if.CS_n, 2'b11);
      drive(2'b00, 2'b11, 2'b00, 2'b00);
      tick();
      check("s1_gnt_off", bus_if.gnt, 2'b00);
      check("s1_guard_busy", bus_if.busy, 1'b1);
      tick(); tick(); tick();
      check("s1_guard3_busy", bus_if.busy, 1'b1);
      tick();
      check("s1_idle_busy", bus_if.busy, 1'b0);

      // 2: both requesting, round robin with guard gap
      do_reset();
      drive(2'b11, 2'b11, 2'b00, 2'b00);
      cyc = 0; ngr = 0; fall_cyc = 0; viol = 0; gap_viol = 0;
      age[0] = 0; age[1] = 0; prev = 2'b00;
      while (ngr < 4 && cyc < 300) begin
         tick();
         cyc++;
         g = bus_if.gnt;
         if (g == 2'b11 || bus_if.CS_n == 2'b00) viol++;
         if (prev == 2'b00 && g != 2'b00) begin
            if (ngr > 0) check($sformatf("s2_gap%0d", ngr), 32'(cyc - fall_cyc), 32'd5);
            check($sformatf("s2_order%0d", ngr), g, (ngr % 2 == 0) ? 2'b01 : 2'b10);
            ngr++;
         end
         if (prev != 2'b00 && g == 2'b00) fall_cyc = cyc;
         if (g == 2'b00 && ngr > 0 && bus_if.CS_n != 2'b11) gap_viol++;
         prev = g;
         for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
               age[i]++;
               if (age[i] == 6) begin
                  bus_if.req[i] = 1'b0;
                  age[i] = 0;
               end
            end else if (!bus_if.req[i]) begin
               bus_if.req[i] = 1'b1;
            end
         end
         bus_if.m_cs_n = ~g;
      end
      check("s2_ngrants", ngr, 4);
      check("s2_onehot_cs", viol, 0);
      check("s2_gap_cs", gap_viol, 0);

      // 3: hold timeout, lockout until req drops
      do_reset();
      drive(2'b10, 2'b11, 2'b00, 2'b00);
      tick();
      check("s3_gnt", bus_if.gnt, 2'b10);
      n = 1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus_if.gnt == 2'b00) break;
         n++;
      end
      check("s3_hold_len", n, 16);
      check("s3_tmo", bus_if.timeout, 1'b1);
      tick();
      check("s3_tmo_pulse", bus_if.timeout, 1'b0);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus_if.gnt != 2'b00) bad++;
      end
      check("s3_lockout", bad, 0);
      check("s3_idle", bus_if.busy, 1'b0);
      drive(2'b00, 2'b11, 2'b00, 2'b00);
      tick();
      drive(2'b10, 2'b11, 2'b00, 2'b00);
      tick();
      check("s3_regrant", bus_if.gnt, 2'b10);

      // 4: reset mid-transfer
      do_reset();
      drive(2'b01, 2'b11, 2'b00, 2'b00);
      tick();
      drive(2'b01, 2'b10, 2'b01, 2'b01);
      tick();
      check("s4_pre_gnt", bus_if.gnt, 2'b01);
      check("s4_pre_cs", bus_if.CS_n, 2'b10);
      check("s4_pre_sclk", bus_if.SCLK, 1'b1);
      Reset = 1'b0;
      drive(2'b11, 2'b10, 2'b01, 2'b01);
      tick();
      check("s4_gnt", bus_if.gnt, 2'b00);
      check("s4_cs", bus_if.CS_n, 2'b11);
      check("s4_sclk", bus_if.SCLK, 1'b0);
      check("s4_busy", bus_if.busy, 1'b0);
      Reset = 1'b1;
      drive(2'b11, 2'b11, 2'b00, 2'b00);
      tick();
      check("s4_first", bus_if.gnt, 2'b01);

      // 5: other requester waits through GRANT and GUARD
      do_reset();
      drive(2'b01, 2'b11, 2'b00, 2'b00);
      tick();
      drive(2'b11, 2'b00, 2'b00, 2'b00);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus_if.gnt[1] || !bus_if.CS_n[1]) bad++;
      end
      check("s5_wait", bad, 0);
      drive(2'b10, 2'b11, 2'b00, 2'b00);
      tick();
      check("s5_rel", bus_if.gnt, 2'b00);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (bus_if.gnt == 2'b10) break;
      end
      check("s5_gap", n, 5);

      // 6: release on the last hold cycle wins over timeout
      do_reset();
      drive(2'b01, 2'b11, 2'b00, 2'b00);
      tick();
      check("s6_gnt", bus_if.gnt, 2'b01);
      for (int k = 0; k < 15; k++) tick();
      check("s6_still", bus_if.gnt, 2'b01);
      drive(2'b00, 2'b11, 2'b00, 2'b00);
      tick();
      check("s6_rel", bus_if.gnt, 2'b00);
      check("s6_no_tmo", bus_if.timeout, 1'b0);
      drive(2'b01, 2'b11, 2'b00, 2'b00);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (bus_if.gnt == 2'b01) break;
      end
      check("s6_regrant_gap", n, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
